// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and address helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0]  SZ_B = 2'd0;
  localparam logic [1:0]  SZ_H = 2'd1;
  localparam logic [1:0]  SZ_W = 2'd2;
  localparam logic [31:0] MEM_RLEN_WORD = 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  // Encoding 3 has no meaning of its own and behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SZ_W : size;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    return lo;
      SZ_H:    return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request/response bundle of the load/store unit.
interface lsu_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_wen;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane datapath: load extraction/extension and sub-word store merge.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] ext_data,
  output logic [31:0] merged_word
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  assign sh      = {offset, 3'b000};
  assign shifted = rd_word >> sh;

  always_comb begin
    ext_data = shifted;
    case (size)
      SZ_B:    ext_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SZ_H:    ext_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

  // Offset is already lane-aligned for the size, so a shifted mask selects the lane.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    case (size)
      SZ_B:    lane_mask = 32'h0000_00FF << sh;
      SZ_H:    lane_mask = 32'h0000_FFFF << sh;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
    merged_word = (rd_word & ~lane_mask) | ((wr_data << sh) & lane_mask);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the word-wide data RAM.
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  lsu_if.slave          req_bus,
  output logic          mem_valid,
  output logic          mem_wen,
  output logic [31:0]   mem_rlen,
  output logic [AW-1:0] mem_raddr,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state, state_n;
  logic          ready, accept, resp_valid;
  logic          wen_q, sgn_q, err_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  logic [1:0]    size_n, lo_n;
  logic          trap;
  logic [31:0]   ext_data, merged_word;

  assign size_n = norm_size(req_bus.req_size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(size_n, req_bus.req_addr[1:0]);
  assign lo_n = req_bus.req_addr[1:0];
`else
  assign trap = 1'b0;
  assign lo_n = align_lo(size_n, req_bus.req_addr[1:0]);
`endif

  assign accept = req_bus.req_valid && ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_n    = state;
    ready      = 1'b0;
    mem_valid  = 1'b0;
    mem_wen    = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        ready = !rst;
        if (req_bus.req_valid && !rst) begin
          if (trap)                  state_n = RESP;
          else if (!req_bus.req_wen) state_n = LOAD;
          else if (size_n == SZ_W)   state_n = WRITE;
          else                       state_n = RMW_RD;
        end
      end
      LOAD: begin
        mem_valid = 1'b1;
        state_n   = RESP;
      end
      RMW_RD: begin
        mem_valid = 1'b1;
        state_n   = WRITE;
      end
      WRITE: begin
        mem_wen = 1'b1;
        state_n = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // data_q holds store data after accept, then the load result or merged word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q  <= 1'b0;
      sgn_q  <= 1'b0;
      err_q  <= 1'b0;
      size_q <= SZ_B;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          wen_q  <= req_bus.req_wen;
          sgn_q  <= req_bus.req_signed;
          err_q  <= trap;
          size_q <= size_n;
          addr_q <= {req_bus.req_addr[AW-1:2], lo_n};
          data_q <= req_bus.req_wen ? req_bus.req_wdata : '0;
        end
        LOAD:    data_q <= ext_data;
        RMW_RD:  data_q <= merged_word;
        default: ;
      endcase
    end
  end

  lsu_lane u_lane (
    .rd_word     (mem_rdata),
    .wr_data     (data_q),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_signed   (sgn_q),
    .ext_data    (ext_data),
    .merged_word (merged_word)
  );

  assign req_bus.req_ready  = ready;
  assign req_bus.resp_valid = resp_valid;
  assign req_bus.resp_err   = resp_valid && err_q;
  assign req_bus.resp_rdata = (resp_valid && !wen_q && !err_q) ? data_q : '0;

  assign mem_rlen  = MEM_RLEN_WORD;
  assign mem_raddr = {addr_q[AW-1:2], 2'b00};
  assign mem_waddr = {addr_q[AW-1:2], 2'b00};
  assign mem_wdata = data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a small word-wide RAM model.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_wen;
  logic [31:0] mem_rlen, mem_raddr, mem_waddr, mem_wdata, mem_rdata;

  logic [31:0] ram [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_if #(.AW(32), .DW(32)) bus ();

  lsu_ctrl #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_bus   (bus),
    .mem_valid (mem_valid),
    .mem_wen   (mem_wen),
    .mem_rlen  (mem_rlen),
    .mem_raddr (mem_raddr),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM ignores writes whose address has bit 28 set.
  always @(posedge clk) begin
    if (bd_we)                         ram[bd_idx] <= bd_data;
    else if (mem_wen && !mem_waddr[28]) ram[mem_waddr[9:2]] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_raddr[9:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = a[9:2]; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  function automatic logic [31:0] peek(input logic [31:0] a);
    return ram[a[9:2]];
  endfunction

  task automatic do_req(input logic wen, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nwen, output int nval);
    lat = -1; rd = '0; er = 1'b0; nwen = 0; nval = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    check("ready_idle", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_wen)   nwen++;
      if (mem_valid) nval++;
      if (bus.resp_valid) begin
        lat = k; rd = bus.resp_rdata; er = bus.resp_err;
        break;
      end
    end
    @(negedge clk);
    check("resp_one_cycle", {31'b0, bus.resp_valid}, 32'd0);
  endtask

  int          lat, nwen, nval, cnt;
  logic [31:0] rd;
  logic        er;

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  {31'b0, bus.req_ready}, 32'd0);
    check("rst_resp",   {31'b0, bus.resp_valid}, 32'd0);
    check("rst_memvld", {31'b0, mem_valid}, 32'd0);
    check("rst_memwen", {31'b0, mem_wen}, 32'd0);
    check("rst_rlen",   mem_rlen, 32'd4);
    check("rst_wdata",  mem_wdata, 32'd0);
    rst = 1'b0;

    poke(32'h100, 32'h80FF7F01);
    poke(32'h200, 32'h11223344);
    poke(32'h300, 32'h0BADF00D);

    do_req(1'b0, SZ_B, 1'b1, 32'h103, 32'h0, lat, rd, er, nwen, nval);
    check("ld_b_s_data", rd, 32'hFFFFFF80);
    check("ld_b_s_lat",  lat, 32'd2);
    check("ld_b_s_nval", nval, 32'd1);
    do_req(1'b0, SZ_B, 1'b0, 32'h103, 32'h0, lat, rd, er, nwen, nval);
    check("ld_b_u_data", rd, 32'h00000080);
    do_req(1'b0, SZ_B, 1'b1, 32'h100, 32'h0, lat, rd, er, nwen, nval);
    check("ld_b_s_pos",  rd, 32'h00000001);
    do_req(1'b0, SZ_H, 1'b1, 32'h102, 32'h0, lat, rd, er, nwen, nval);
    check("ld_h_s_data", rd, 32'hFFFF80FF);
    do_req(1'b0, SZ_W, 1'b0, 32'h100, 32'h0, lat, rd, er, nwen, nval);
    check("ld_w_data",   rd, 32'h80FF7F01);
    check("ld_w_lat",    lat, 32'd2);
    check("ld_w_nowen",  nwen, 32'd0);

    do_req(1'b1, SZ_B, 1'b0, 32'h201, 32'h000000AA, lat, rd, er, nwen, nval);
    check("st_b_lat",  lat, 32'd3);
    check("st_b_nwen", nwen, 32'd1);
    check("st_b_rd0",  rd, 32'd0);
    check("st_b_ram",  peek(32'h200), 32'h1122AA44);

    poke(32'h200, 32'h11223344);
    do_req(1'b1, SZ_H, 1'b0, 32'h202, 32'h0000BEEF, lat, rd, er, nwen, nval);
    check("st_h_lat",  lat, 32'd3);
    check("st_h_ram",  peek(32'h200), 32'hBEEF3344);

    do_req(1'b1, SZ_W, 1'b0, 32'h204, 32'hDEADBEEF, lat, rd, er, nwen, nval);
    check("st_w_lat",  lat, 32'd2);
    check("st_w_nwen", nwen, 32'd1);
    check("st_w_nval", nval, 32'd0);
    check("st_w_ram",  peek(32'h204), 32'hDEADBEEF);

    // Size encoding 3 behaves as a word load.
    do_req(1'b0, 2'd3, 1'b0, 32'h204, 32'h0, lat, rd, er, nwen, nval);
    check("ld_sz3_data", rd, 32'hDEADBEEF);

    do_req(1'b1, SZ_W, 1'b0, 32'h10000300, 32'h12345678, lat, rd, er, nwen, nval);
    check("b28_lat", lat, 32'd2);
    check("b28_ram", peek(32'h300), 32'h0BADF00D);

    // Reset while the FSM sits in RMW_RD abandons the store.
    poke(32'h208, 32'h55667788);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_size = SZ_B;
    bus.req_signed = 1'b0; bus.req_addr = 32'h208; bus.req_wdata = 32'h99;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_memvld", {31'b0, mem_valid}, 32'd1);
    rst = 1'b1;
    cnt = 0;
    @(negedge clk);
    if (mem_wen || bus.resp_valid) cnt++;
    check("rst_mid_ready", {31'b0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_ready", {31'b0, bus.req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (mem_wen || bus.resp_valid) cnt++;
      @(negedge clk);
    end
    check("rst_mid_quiet", cnt, 32'd0);
    check("rst_mid_ram",   peek(32'h208), 32'h55667788);

    do_req(1'b0, SZ_H, 1'b0, 32'h101, 32'h0, lat, rd, er, nwen, nval);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_lat",  lat, 32'd1);
    check("mis_err",  {31'b0, er}, 32'd1);
    check("mis_nval", nval, 32'd0);
    check("mis_data", rd, 32'd0);
`else
    check("mis_lat",  lat, 32'd2);
    check("mis_err",  {31'b0, er}, 32'd0);
    check("mis_nval", nval, 32'd1);
    check("mis_data", rd, 32'h00007F01);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the data RAM. Sits between the execute stage and the RAM.
- Accepts one memory request at a time from execute over a valid/ready handshake.
- Drives the RAM's combinational-read / clocked full-word-write port.
- Performs byte-lane extraction and sign/zero extension for loads.
- Performs read-modify-write for byte and halfword stores, because the RAM writes whole words only.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed to 32, other values unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  execute presents a request
- req_ready  out  1  request accepted when high with req_valid
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word; 3 is treated as word
- req_signed  in  1  sign-extend a load result
- req_addr  in  AW  byte address
- req_wdata  in  DW  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DW  extended load data; 0 for stores
- resp_err  out  1  misaligned access; meaningful only with LSU_MISALIGN_TRAP_EN
- mem_valid  out  1  RAM read enable
- mem_wen  out  1  RAM write enable
- mem_rlen  out  32  always 32'd4; full-word reads, lane select is done here
- mem_raddr  out  AW  word-aligned read address (low 2 bits 0)
- mem_waddr  out  AW  word-aligned write address
- mem_wdata  out  DW  full word to write
- mem_rdata  in  DW  combinational RAM read data

Behaviour:
- Reset: synchronous, active-high, on clk. All outputs 0 except mem_rlen = 4. State = IDLE. Captured request registers cleared.
- Reset mid-operation: the transaction is abandoned. No resp_valid is issued. mem_wen is 0 from the cycle after rst is sampled.
- Handshake: req_ready = 1 only in IDLE. Request fields are captured on the clk edge where req_valid && req_ready. No back-to-back acceptance; the next accept is at the earliest in the cycle after resp_valid.
- State IDLE: on accept, go to
  - LOAD if req_wen = 0;
  - WRITE if store and size = word;
  - RMW_RD if store and size = byte or half.
- State LOAD:
  - mem_valid = 1; mem_raddr = {addr[AW-1:2], 2'b00}.
  - Shift mem_rdata right by 8*addr[1:0] and mask to size.
  - Sign-extend if req_signed, else zero-extend.
  - Register the result into resp_rdata, then go to RESP.
- State RMW_RD:
  - mem_valid = 1; capture mem_rdata.
  - Merge: replace byte lane addr[1:0] (byte) or halfword lane addr[1] (half) with the low bits of wdata.
  - Register the merged word, then go to WRITE.
- State WRITE: mem_wen = 1 for exactly one cycle. mem_waddr = word-aligned address. mem_wdata = merged or raw word. Then go to RESP.
- State RESP: resp_valid = 1 for one cycle; resp_rdata holds its value only in this cycle. Then go to IDLE.
- Latency, accept edge to resp_valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles.
- mem_valid is 0 outside LOAD and RMW_RD. mem_wen is 0 outside WRITE.
- Addresses with bit 28 set are passed through unchanged; the RAM discards those writes. The LSU still completes normally.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
  - A misaligned request goes IDLE -> RESP directly, with resp_err = 1 and resp_rdata = 0.
  - No RAM read or write is issued.
- Undefined:
  - Offending low address bits are forced to 0 (half: addr[0]; word: addr[1:0]).
  - The access proceeds aligned; resp_err is tied 0.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  - state enum IDLE, LOAD, RMW_RD, WRITE, RESP;
  - constant MEM_RLEN_WORD = 32'd4.
- Sub-module lsu_lane (combinational), containing:
  - extract: word, offset, size, signed -> data;
  - merge: old word, new data, offset, size -> word.
- Top-level lsu_ctrl holds the FSM and registers.

Test Plan:
- RAM word 0x100 = 0x80FF7F01; load byte signed at 0x103 -> resp_rdata 0xFFFFFF80 two cycles after accept. Same access unsigned -> 0x00000080.
- Same word; load half signed at 0x102 -> 0xFFFF80FF. Load word at 0x100 -> 0x80FF7F01.
- Word 0x200 = 0x11223344; store byte 0xAA at 0x201 -> RAM holds 0x1122AA44. mem_wen pulses exactly once, resp_valid 3 cycles after accept.
- Store half 0xBEEF at 0x202 onto 0x11223344 -> 0xBEEF3344. Word store 0xDEADBEEF at 0x204 -> RAM updated, resp 2 cycles after accept.
- rst asserted in the cycle the FSM is in RMW_RD -> no mem_wen, no resp_valid, RAM unchanged. req_ready = 1 in the cycle after rst deasserts.
- Half load at 0x101:
  - with LSU_MISALIGN_TRAP_EN: resp_err = 1 one cycle after accept, no mem_valid.
  - without it: reads the half at 0x100, resp_err = 0.
